ascon_tag_unit: RTL and testbench
=================================

Name: ascon_tag_unit

Overview:
- Tag handling stage at the end of the ASCON-128 datapath.
- Captures the finalisation tag from the permutation state in one cycle, then runs in one of two modes:
  - Encrypt: serialises the tag onto a narrow valid/ready output bus, most-significant word first.
  - Decrypt: consumes the received tag as a word stream and performs a constant-time compare, reporting pass/fail.
- Generalises the plain 128-bit enabled tag register in tag width, bus width and mode.

Parameters:
- TAG_W, 128, tag width in bits.
- BUS_W, 32, stream word width; must divide TAG_W (elaboration assertion).
- NB, TAG_W/BUS_W, beats per tag (derived localparam, not overridable).

Ports:
- clock_i  in  1  clock, rising edge.
- resetb_i  in  1  reset, asynchronous, active-low.
- clear_i  in  1  synchronous abort/clear, highest priority after reset.
- load_en_i  in  1  capture tag_i and mode_i this cycle.
- mode_i  in  1  0 = encrypt (stream out), 1 = decrypt (verify).
- tag_i  in  TAG_W  tag from finalisation.
- out_data_o  out  BUS_W  serialised tag word.
- out_valid_o  out  1  out_data_o valid.
- out_ready_i  in  1  downstream accepts word.
- out_last_o  out  1  final beat flag, qualified by out_valid_o.
- ref_data_i  in  BUS_W  received tag word (decrypt).
- ref_valid_i  in  1  ref_data_i valid.
- ref_ready_o  out  1  unit accepts ref word.
- done_o  out  1  operation complete (level, held in DONE).
- tag_ok_o  out  1  verify result; valid only when done_o=1 and mode=1.

Behaviour:
- Reset: all outputs 0; tag register, beat counter and diff accumulator 0; FSM = IDLE.
- States: IDLE, STREAM, VERIFY, DONE. Enum type lives in the package.
- IDLE:
  - On load_en_i: tag_r <= tag_i, mode_r <= mode_i, cnt <= 0, diff <= 0.
  - Next state is STREAM if mode_i=0, else VERIFY. Latency from load to first valid beat: 1 cycle.
- STREAM:
  - out_valid_o=1; out_data_o = tag_r[TAG_W-1 -: BUS_W].
  - On out_valid_o & out_ready_i: tag_r shifts left by BUS_W (zero fill), cnt++.
  - out_last_o=1 when cnt==NB-1. A handshake on the last beat goes to DONE.
  - out_ready_i low: data and valid held stable (AXI-style, no retraction).
- VERIFY:
  - ref_ready_o=1; out_valid_o=0; the tag is never driven on out_data_o in this mode (out_data_o=0).
  - On ref_valid_i: diff <= diff | (tag_r[TAG_W-1 -: BUS_W] ^ ref_data_i); tag_r shifts, cnt++.
  - After NB beats go to DONE.
  - No early exit on mismatch: always exactly NB beats (constant time).
- DONE:
  - done_o=1. tag_ok_o = (diff==0) if mode_r=1, else 0.
  - On a verify failure, tag_r is zeroed on entry to DONE.
  - Held until clear_i or load_en_i. load_en_i in DONE behaves as in IDLE (back-to-back operation).
- load_en_i in STREAM/VERIFY is ignored; no mid-operation restart.
- clear_i, any state: next cycle IDLE, tag_r/diff/cnt zeroed, all outputs 0. clear_i beats a simultaneous load_en_i.
- Async reset mid-operation: immediate return to reset values; a partial stream is not resumed.
- cnt width is $clog2(NB), minimum 1. Counter wrap is not used; the state transition governs.
- NB=1 (BUS_W=TAG_W): a single beat, with out_last_o=1 on the first beat.

Decomposition:
- ascon_pack:
  - tag_state_t enum {IDLE, STREAM, VERIFY, DONE}.
  - Constants TAG_WIDTH=128 and MODE_ENC=0 / MODE_DEC=1.
- Single module; no sub-module. The shift register, counter and comparator are each too small to justify separate modules.

Test Plan:
- Encrypt, out_ready_i=1, tag=128'h0123456789ABCDEF_FEDCBA9876543210 -> beats 01234567, 89ABCDEF, FEDCBA98, 76543210 on consecutive cycles; out_last_o on beat 4; done_o the cycle after; tag_ok_o=0.
- Encrypt with out_ready_i toggling 1,0,0,1,... -> data and valid stable while stalled, same 4 words in order, no duplicates or drops.
- Decrypt, ref words equal to tag, with ref_valid_i gaps -> done_o after 4 accepted beats, tag_ok_o=1, out_valid_o never 1.
- Decrypt, only the first ref word differs (01234566) -> still 4 beats consumed, tag_ok_o=0, internal tag_r == 0 in DONE.
- clear_i asserted after beat 2 of STREAM -> next cycle IDLE, all outputs 0; a new load then streams from word 0.
- resetb_i pulsed low mid-VERIFY -> outputs 0 asynchronously; load_en_i asserted in the same cycle as clear_i is ignored.

Source files
------------

// File: rtl/ascon_tag_unit_pkg.sv
// Shared types and constants for the ASCON-128 tag handling stage.
package ascon_pack;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        VERIFY = 2'd2,
        DONE   = 2'd3
    } tag_state_t;

    localparam int   TAG_WIDTH = 128;
    localparam logic MODE_ENC  = 1'b0;
    localparam logic MODE_DEC  = 1'b1;

endpackage

// File: rtl/ascon_tag_unit.sv
// ASCON-128 tag stage: captures the finalisation tag, then either streams it
// out MSW-first (encrypt) or compares it in constant time against a received tag (decrypt).
module ascon_tag_unit
    import ascon_pack::*;
#(
    parameter int TAG_W = TAG_WIDTH,
    parameter int BUS_W = 32
) (
    input  logic             clock_i,
    input  logic             resetb_i,
    input  logic             clear_i,
    input  logic             load_en_i,
    input  logic             mode_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic [BUS_W-1:0] out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             out_last_o,
    input  logic [BUS_W-1:0] ref_data_i,
    input  logic             ref_valid_i,
    output logic             ref_ready_o,
    output logic             done_o,
    output logic             tag_ok_o
);

    localparam int NB = TAG_W / BUS_W;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;

    if ((TAG_W % BUS_W) != 0) begin : g_bad_widths
        $error("ascon_tag_unit: BUS_W must divide TAG_W");
    end

    tag_state_t       state_reg, state_next;
    logic [TAG_W-1:0] tag_reg, tag_next;
    logic             mode_reg, mode_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [BUS_W-1:0] diff_reg, diff_next;

    logic [BUS_W-1:0] head_word;
    logic [TAG_W-1:0] tag_shifted;
    logic             is_last;

    assign head_word   = tag_reg[TAG_W-1 -: BUS_W];
    assign tag_shifted = tag_reg << BUS_W;
    assign is_last     = (cnt_reg == CW'(NB - 1));

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_reg <= IDLE;
            tag_reg   <= '0;
            mode_reg  <= MODE_ENC;
            cnt_reg   <= '0;
            diff_reg  <= '0;
        end else begin
            state_reg <= state_next;
            tag_reg   <= tag_next;
            mode_reg  <= mode_next;
            cnt_reg   <= cnt_next;
            diff_reg  <= diff_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        tag_next    = tag_reg;
        mode_next   = mode_reg;
        cnt_next    = cnt_reg;
        diff_next   = diff_reg;
        out_data_o  = '0;
        out_valid_o = 1'b0;
        out_last_o  = 1'b0;
        ref_ready_o = 1'b0;
        done_o      = 1'b0;
        tag_ok_o    = 1'b0;

        case (state_reg)
            IDLE, DONE: begin
                if (state_reg == DONE) begin
                    done_o   = 1'b1;
                    tag_ok_o = (mode_reg == MODE_DEC) && (diff_reg == '0);
                end
                if (load_en_i) begin
                    tag_next   = tag_i;
                    mode_next  = mode_i;
                    cnt_next   = '0;
                    diff_next  = '0;
                    state_next = (mode_i == MODE_DEC) ? VERIFY : STREAM;
                end
            end
            STREAM: begin
                out_valid_o = 1'b1;
                out_data_o  = head_word;
                out_last_o  = is_last;
                if (out_ready_i) begin
                    tag_next = tag_shifted;
                    cnt_next = cnt_reg + CW'(1);
                    if (is_last) begin
                        state_next = DONE;
                    end
                end
            end
            VERIFY: begin
                ref_ready_o = 1'b1;
                if (ref_valid_i) begin
                    // Every beat is consumed regardless of earlier mismatches.
                    diff_next = diff_reg | (head_word ^ ref_data_i);
                    tag_next  = tag_shifted;
                    cnt_next  = cnt_reg + CW'(1);
                    if (is_last) begin
                        state_next = DONE;
                        if (diff_next != '0) begin
                            tag_next = '0;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // Abort wins over any capture or handshake in the same cycle.
        if (clear_i) begin
            state_next = IDLE;
            tag_next   = '0;
            mode_next  = MODE_ENC;
            cnt_next   = '0;
            diff_next  = '0;
        end
    end

endmodule

// File: tb/tb_ascon_tag_unit.sv
// Scoreboard bench for ascon_tag_unit: stimulus queues expected beats/results, a monitor checks them.
module tb_ascon_tag_unit;

    logic         clk = 1'b0;
    logic         rstb = 1'b0;
    logic         clear = 1'b0;
    logic         load = 1'b0;
    logic         mode = 1'b0;
    logic [127:0] tag = '0;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         out_last;
    logic [31:0]  ref_data = '0;
    logic         ref_valid = 1'b0;
    logic         ref_ready;
    logic         done;
    logic         tag_ok;

    int passed = 0;
    int total  = 0;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t beat_q[$];
    logic  result_q[$];
    bit    verify_phase = 1'b0;

    localparam logic [127:0] T1 = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [127:0] T2 = 128'hDEADBEEF_CAFEBABE_0BADF00D_12345678;

    ascon_tag_unit #(.TAG_W(128), .BUS_W(32)) dut (
        .clock_i    (clk),
        .resetb_i   (rstb),
        .clear_i    (clear),
        .load_en_i  (load),
        .mode_i     (mode),
        .tag_i      (tag),
        .out_data_o (out_data),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_last_o (out_last),
        .ref_data_i (ref_data),
        .ref_valid_i(ref_valid),
        .ref_ready_o(ref_ready),
        .done_o     (done),
        .tag_ok_o   (tag_ok)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_beats(input logic [127:0] t);
        for (int i = 0; i < 4; i++) begin
            beat_t b;
            b.data = t[127-32*i -: 32];
            b.last = (i == 3);
            beat_q.push_back(b);
        end
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 60) begin
            tick();
            n++;
        end
        check(name, done, 1'b1);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // Monitor: pops expected beats on handshakes, results on done rising.
    logic        done_d = 1'b0;
    logic        stall_prev = 1'b0;
    logic [31:0] stall_data = '0;
    always @(negedge clk) begin
        if (!rstb) begin
            done_d     = 1'b0;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", out_valid, 1'b1);
                check("stall_data", out_data, stall_data);
            end
            stall_prev = out_valid && !out_ready && !clear;
            stall_data = out_data;
            if (out_valid && out_ready) begin
                if (beat_q.size() == 0) begin
                    total++;
                    $display("FAIL beat_unexpected: got %0h, want no beat", out_data);
                end else begin
                    beat_t b;
                    b = beat_q.pop_front();
                    check("beat_data", out_data, b.data);
                    check("beat_last", out_last, b.last);
                end
            end
            if (verify_phase) begin
                check("verify_no_valid", out_valid, 1'b0);
                check("verify_no_data", out_data, 32'h0);
            end
            if (done && !done_d) begin
                if (result_q.size() == 0) begin
                    total++;
                    $display("FAIL done_unexpected: got done=1, want none");
                end else begin
                    check("tag_ok", tag_ok, result_q.pop_front());
                end
            end
            done_d = done;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat;
        pat = 8'b0101_1001;   // ready sequence 1,0,0,1,1,0,1,0

        #12;
        check("rst_valid", out_valid, 1'b0);
        check("rst_ready", ref_ready, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_tag", dut.tag_reg, 128'h0);
        @(posedge clk);
        #1 rstb = 1'b1;
        tick();

        // Encrypt, ready always high; a second load mid-stream must be ignored.
        out_ready = 1'b1;
        load = 1'b1; mode = 1'b0; tag = T1;
        push_beats(T1);
        result_q.push_back(1'b0);
        tick();
        tag = T2; mode = 1'b1;
        check("enc_latency", out_valid, 1'b1);
        tick();
        load = 1'b0;
        tick(); tick(); tick();
        check("enc_done_cycle", done, 1'b1);
        check("enc_done_novalid", out_valid, 1'b0);
        do_clear();
        check("enc_clear_done", done, 1'b0);

        // Encrypt with back-pressure.
        load = 1'b1; mode = 1'b0; tag = T2;
        push_beats(T2);
        result_q.push_back(1'b0);
        out_ready = pat[0];
        tick();
        load = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            out_ready = pat[k % 8];
            tick();
        end
        check("stall_done", done, 1'b1);
        out_ready = 1'b0;

        // Decrypt straight from DONE (back-to-back), matching words with gaps.
        load = 1'b1; mode = 1'b1; tag = T1;
        result_q.push_back(1'b1);
        tick();
        load = 1'b0;
        verify_phase = 1'b1;
        check("dec_ready", ref_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) begin
                ref_valid = 1'b0;
                tick();
            end
            check("dec_not_early", done, 1'b0);
            ref_valid = 1'b1;
            ref_data  = T1[127-32*i -: 32];
            tick();
            ref_valid = 1'b0;
        end
        verify_phase = 1'b0;
        check("dec_done", done, 1'b1);
        check("dec_done_noready", ref_ready, 1'b0);
        do_clear();

        // Decrypt with the first word corrupted: still exactly four beats.
        load = 1'b1; mode = 1'b1; tag = T1;
        result_q.push_back(1'b0);
        tick();
        load = 1'b0;
        verify_phase = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("fail_not_early", done, 1'b0);
            ref_valid = 1'b1;
            ref_data  = (i == 0) ? 32'h01234566 : T1[127-32*i -: 32];
            tick();
        end
        ref_valid = 1'b0;
        verify_phase = 1'b0;
        check("fail_done", done, 1'b1);
        check("fail_tag_zero", dut.tag_reg, 128'h0);
        do_clear();

        // Clear after two streamed beats, then restart from word 0.
        out_ready = 1'b1;
        load = 1'b1; mode = 1'b0; tag = T1;
        push_beats(T1);
        tick();
        load = 1'b0;
        tick(); tick();
        clear = 1'b1; out_ready = 1'b0;
        tick();
        clear = 1'b0;
        void'(beat_q.pop_back());
        void'(beat_q.pop_back());
        check("clr_valid", out_valid, 1'b0);
        check("clr_last", out_last, 1'b0);
        check("clr_data", out_data, 32'h0);
        check("clr_done", done, 1'b0);
        check("clr_tag", dut.tag_reg, 128'h0);
        out_ready = 1'b1;
        load = 1'b1; tag = T1; mode = 1'b0;
        push_beats(T1);
        result_q.push_back(1'b0);
        tick();
        load = 1'b0;
        wait_done("restart_done");
        out_ready = 1'b0;

        // Clear and load together: clear wins.
        clear = 1'b1; load = 1'b1; mode = 1'b0; tag = T2;
        tick();
        clear = 1'b0; load = 1'b0;
        check("clrload_valid", out_valid, 1'b0);
        check("clrload_done", done, 1'b0);
        check("clrload_tag", dut.tag_reg, 128'h0);

        // Asynchronous reset mid-verify.
        load = 1'b1; mode = 1'b1; tag = T2;
        tick();
        load = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ref_valid = 1'b1;
            ref_data  = T2[127-32*i -: 32];
            tick();
        end
        ref_valid = 1'b0;
        check("pre_rst_ready", ref_ready, 1'b1);
        #2 rstb = 1'b0;
        #1;
        check("async_rst_ready", ref_ready, 1'b0);
        check("async_rst_cnt", dut.cnt_reg, 2'd0);
        check("async_rst_tag", dut.tag_reg, 128'h0);
        @(posedge clk);
        #1 rstb = 1'b1;
        tick();
        check("post_rst_ready", ref_ready, 1'b0);
        check("post_rst_done", done, 1'b0);

        tick();
        check("beat_q_empty", beat_q.size(), 0);
        check("result_q_empty", result_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
